hazard_ctrl_unit: RTL

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_pkg.sv | 43 ++++
 rtl/hazard_perf_counter.sv | 26 ++
 rtl/hazard_ctrl_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_e : controller FSM states (RUN / MEM_WAIT / FAULT)
//   hazard_ctrl_t  : bundle of stall/flush controls driven to the pipeline
//   REG_IDX_W      : architectural register index width
//   PERF_CNT_W     : performance counter width
package hazard_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hazard_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctrl_t;

  // Every stage frozen and a bubble pushed into writeback.
  localparam hazard_ctrl_t CTRL_HOLD_ALL = '{
    stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
    flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1
  };

  // Load-use hazard: Execute load writes a register Decode reads (x0 exempt).
  function automatic logic load_use_hazard(
    input logic                 load_e,
    input logic [REG_IDX_W-1:0] rd_e,
    input logic [REG_IDX_W-1:0] rs1_d,
    input logic [REG_IDX_W-1:0] rs2_d
  );
    return load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running 32-bit event counter, wraps at 2^32.
//   clk, rst_n : clock, async active-low reset
//   i_en       : count this cycle
//   o_count    : current count (registered)
module hazard_perf_counter
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  output logic [PERF_CNT_W-1:0] o_count
);

  logic [PERF_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + PERF_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes,
// data-memory wait stalls with a timeout fault.
//   clk, reset_n              : clock, async active-low reset
//   Rs1D, Rs2D, RdE, LoadE    : load-use detection inputs
//   PCSrcE                    : taken branch/jump resolved in Execute
//   MemReqM, MemReadyM        : data-memory handshake in Memory stage
//   StallF/D/E/M, FlushD/E/W  : pipeline controls (combinational)
//   MemTimeoutErr             : sticky timeout fault, cleared only by reset
//   StallCnt, FlushCnt        : perf counters, present only when the
//                               HAZARD_PERF_CNT_EN macro is defined, else 0
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_IDX_W-1:0]  Rs1D,
  input  logic [REG_IDX_W-1:0]  Rs2D,
  input  logic [REG_IDX_W-1:0]  RdE,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemTimeoutErr,
  output logic [PERF_CNT_W-1:0] StallCnt,
  output logic [PERF_CNT_W-1:0] FlushCnt
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_e r_state;
  hazard_state_e w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;

  logic         w_lw_stall;
  logic         w_mem_busy;
  hazard_ctrl_t w_run_ctrl;
  hazard_ctrl_t w_ctrl;

  assign w_lw_stall = load_use_hazard(LoadE, RdE, Rs1D, Rs2D);
  assign w_mem_busy = MemReqM & ~MemReadyM;

  // Normal-flow controls: load-use stall plus redirect flush.
  always_comb begin
    w_run_ctrl         = '0;
    w_run_ctrl.stall_f = w_lw_stall;
    w_run_ctrl.stall_d = w_lw_stall;
    w_run_ctrl.flush_d = PCSrcE;
    w_run_ctrl.flush_e = w_lw_stall | PCSrcE;
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next state. The counter tops out at MEM_TIMEOUT on entry to FAULT and
  // then holds, so it never wraps.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            w_state_nxt = FAULT;
          end
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs. A memory wait masks redirect/load-use; the still-held ID/EX
  // presents them again in the release cycle, so the flush fires once there.
  always_comb begin
    w_ctrl = '0;
    unique case (r_state)
      RUN:      w_ctrl = w_mem_busy ? CTRL_HOLD_ALL : w_run_ctrl;
      MEM_WAIT: w_ctrl = MemReadyM ? w_run_ctrl : CTRL_HOLD_ALL;
      FAULT:    w_ctrl = CTRL_HOLD_ALL;
      default:  w_ctrl = '0;
    endcase
  end

  assign StallF        = w_ctrl.stall_f;
  assign StallD        = w_ctrl.stall_d;
  assign StallE        = w_ctrl.stall_e;
  assign StallM        = w_ctrl.stall_m;
  assign FlushD        = w_ctrl.flush_d;
  assign FlushE        = w_ctrl.flush_e;
  assign FlushW        = w_ctrl.flush_w;
  assign MemTimeoutErr = (r_state == FAULT);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_ctrl.stall_f),
    .o_count (StallCnt)
  );

  hazard_perf_counter u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_en    (w_ctrl.flush_d | w_ctrl.flush_e),
    .o_count (FlushCnt)
  );
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
